// File: rtl/vga_pixel_pipeline_if.sv
// Frame-store read port between the pixel pipeline and the dual frame store.
// Handshake: there is no valid/ready pair here. The pipeline presents rd_addr
// and rd_buf every cycle. The store returns rd_data a fixed RD_LAT cycles
// later, so the data is valid purely by timing and the store can never stall.
interface vga_pixel_pipeline_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_buf;
  logic [7:0]        rd_data;

  // Pipeline side: issues reads, consumes returned pixels.
  modport master (
    output rd_addr,
    output rd_buf,
    input  rd_data
  );

  // Frame-store side: accepts reads, returns pixels.
  modport slave (
    input  rd_addr,
    input  rd_buf,
    output rd_data
  );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// VGA pixel pipeline: decodes H/V counts into active/image/border regions,
// issues frame-store reads for the centred image and delays the syncs to
// match the read latency. It drives 12-bit RGB and owns the frame-aligned
// display buffer swap handshake.
module vga_pixel_pipeline #(
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256,
  parameter int unsigned X_OFF      = 192,
  parameter int unsigned Y_OFF      = 112,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter logic [11:0] BORDER_RGB = 12'h00F
) (
  input  logic                  clk_25MHz,
  input  logic                  reset_n,
  input  logic [10:0]           H_count_value,
  input  logic [10:0]           V_count_value,
  input  logic                  Hsync_in,
  input  logic                  Vsync_in,
  input  logic                  buf_sel_req,
  output logic                  buf_sel_ack,
  vga_pixel_pipeline_if.master  fs,
  output logic                  Hsync,
  output logic                  Vsync,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic [1:0]            dbg_state_o
);

  // Visible area of the 640x480 timing.
  localparam logic [31:0] H_ACTIVE = 32'd640;
  localparam logic [31:0] V_ACTIVE = 32'd480;

  // Image window, plus the one-pixel frame around it.
  localparam logic [31:0] X_LO   = X_OFF;
  localparam logic [31:0] X_HI   = X_OFF + IMG_W;      // first column past image
  localparam logic [31:0] Y_LO   = Y_OFF;
  localparam logic [31:0] Y_HI   = Y_OFF + IMG_H;      // first line past image
  localparam logic [31:0] XB_LO  = X_OFF - 1;
  localparam logic [31:0] YB_LO  = Y_OFF - 1;

  // Buffer swap handshake states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_ACK     = 2'd2
  } swap_state_t;

  // Widened counts so region compares are plain unsigned 32-bit compares.
  logic [31:0] h_w;
  logic [31:0] v_w;
  assign h_w = {21'd0, H_count_value};
  assign v_w = {21'd0, V_count_value};

  // Stage-0 decode results (combinational, registered into the pipe below).
  logic active_d;
  logic in_img_d;
  logic border_d;
  logic frame_clr_d;
  logic boundary_d;

  // Region decode of the incoming counts.
  always_comb begin
    active_d    = 1'b0;
    in_img_d    = 1'b0;
    border_d    = 1'b0;
    frame_clr_d = 1'b0;
    boundary_d  = 1'b0;
    active_d    = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
    in_img_d    = (h_w >= X_LO) && (h_w < X_HI) &&
                  (v_w >= Y_LO) && (v_w < Y_HI);
    border_d    = !in_img_d &&
                  (h_w >= XB_LO) && (h_w <= X_HI) &&
                  (v_w >= YB_LO) && (v_w <= Y_HI);
    // Whole vertical blanking region restarts the image address.
    frame_clr_d = (v_w >= V_ACTIVE);
    // Single-cycle frame boundary used to swap buffers between frames.
    boundary_d  = (v_w == V_ACTIVE) && (h_w == 32'd0);
  end

  // Address generation: rd_addr_q is the address of the pixel currently in
  // stage 0; cnt_q is the number of image pixels already issued this frame.
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] cnt_q;

  // Issue one read per image pixel, hold outside the image, clear in vblank.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else if (frame_clr_d) begin
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else if (in_img_d) begin
      rd_addr_q <= cnt_q;
      cnt_q     <= cnt_q + ADDR_W'(1);
    end
  end

  assign fs.rd_addr = rd_addr_q;

  // Flag and sync delay line. Index 0 is stage 0; index RD_LAT lines up with
  // rd_data returned for the address issued from stage 0.
  logic [RD_LAT:0] act_q;
  logic [RD_LAT:0] img_q;
  logic [RD_LAT:0] brd_q;
  logic [RD_LAT:0] hs_q;
  logic [RD_LAT:0] vs_q;

  // Shift the region flags and syncs; reset leaves every stage blank with
  // syncs inactive so the outputs go dark immediately.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      act_q <= '0;
      img_q <= '0;
      brd_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
    end else begin
      act_q <= {act_q[RD_LAT-1:0], active_d};
      img_q <= {img_q[RD_LAT-1:0], in_img_d};
      brd_q <= {brd_q[RD_LAT-1:0], border_d};
      hs_q  <= {hs_q[RD_LAT-1:0],  Hsync_in};
      vs_q  <= {vs_q[RD_LAT-1:0],  Vsync_in};
    end
  end

  // Colour select at the output stage. rd_data arrives directly from the
  // store at this stage, so it is muxed without a further register.
  logic [11:0] rgb;
  always_comb begin
    rgb = 12'h000;
    if (act_q[RD_LAT] && img_q[RD_LAT]) begin
      rgb = {3{fs.rd_data[7:4]}};
    end else if (act_q[RD_LAT] && brd_q[RD_LAT]) begin
      rgb = BORDER_RGB;
    end
  end

  // Only the top nibble of the grayscale sample reaches the 4-bit DAC.
  logic unused_lsb;
  assign unused_lsb = ^fs.rd_data[3:0];

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];
  assign Hsync = hs_q[RD_LAT];
  assign Vsync = vs_q[RD_LAT];

  // Buffer swap FSM with registered rd_buf/ack. The toggle is only taken on
  // the frame boundary, so the displayed buffer never changes mid-frame.
  swap_state_t state_q;
  logic        rd_buf_q;
  logic        ack_q;

  // Request -> wait for frame boundary -> toggle and ack -> wait for release.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rd_buf_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (buf_sel_req) begin
            state_q <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (buf_sel_req && boundary_d) begin
            rd_buf_q <= ~rd_buf_q;
            ack_q    <= 1'b1;
            state_q  <= S_ACK;
          end else if (!buf_sel_req) begin
            // Request withdrawn before the boundary: no swap.
            state_q <= S_IDLE;
          end
        end
        S_ACK: begin
          if (!buf_sel_req) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fs.rd_buf   = rd_buf_q;
  assign buf_sel_ack = ack_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Testbench for vga_pixel_pipeline: drives H/V counts and syncs, models a
// 2-cycle frame store returning rd_addr[7:0], and compares outputs against
// a region/pixel-count reference model.
module tb_vga_pixel_pipeline;

  localparam int X_OFF = 192;
  localparam int Y_OFF = 112;
  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam logic [13:0] BLANK = 14'h0003;  // rgb 0, Hsync=1, Vsync=1

  // ---------------- clock / reset ----------------
  logic        clk_25MHz;
  logic        reset_n;
  logic [10:0] H_count_value;
  logic [10:0] V_count_value;
  logic        Hsync_in;
  logic        Vsync_in;
  logic        buf_sel_req;
  logic        buf_sel_ack;
  logic        Hsync;
  logic        Vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [1:0]  dbg_state;

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  vga_pixel_pipeline_if #(.ADDR_W(16)) fs_bus ();

  vga_pixel_pipeline dut (
    .clk_25MHz     (clk_25MHz),
    .reset_n       (reset_n),
    .H_count_value (H_count_value),
    .V_count_value (V_count_value),
    .Hsync_in      (Hsync_in),
    .Vsync_in      (Vsync_in),
    .buf_sel_req   (buf_sel_req),
    .buf_sel_ack   (buf_sel_ack),
    .fs            (fs_bus.master),
    .Hsync         (Hsync),
    .Vsync         (Vsync),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .dbg_state_o   (dbg_state)
  );

  // Frame store model: data = low byte of the address, two cycles later.
  logic [7:0] mem_d1_q;
  logic [7:0] mem_d2_q;
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      mem_d1_q <= 8'h00;
      mem_d2_q <= 8'h00;
    end else begin
      mem_d1_q <= fs_bus.rd_addr[7:0];
      mem_d2_q <= mem_d1_q;
    end
  end
  assign fs_bus.rd_data = mem_d2_q;

  logic [13:0] obs_out;
  assign obs_out = {red, green, blue, Hsync, Vsync};

  // ---------------- scoreboard / reference model ----------------
  int          n_chk;
  int          n_pass;
  logic [13:0] exp_q[$];     // expected {rgb,Hsync,Vsync} per driven count
  logic [13:0] exp_out;      // expectation for the outputs right now
  int          m_pixels;     // image pixels presented since last clear
  logic [15:0] m_addr;       // expected rd_addr right now

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(BLANK);
    exp_q.push_back(BLANK);
    exp_out  = BLANK;
    m_pixels = 0;
    m_addr   = 16'h0000;
  endtask

  // ---------------- driver ----------------
  // Present one count, clock it, then update the model. Returns #1 after
  // the edge so the caller samples away from the clock edge.
  task automatic drive(input int h, input int v, input logic hs, input logic vs);
    bit          act;
    bit          img;
    bit          brd;
    logic [11:0] rgb;
    logic [13:0] dropped;
    H_count_value = 11'(h);
    V_count_value = 11'(v);
    Hsync_in      = hs;
    Vsync_in      = vs;
    @(posedge clk_25MHz);
    #1;
    act = (h < 640) && (v < 480);
    img = (h >= X_OFF) && (h < X_OFF + IMG_W) && (v >= Y_OFF) && (v < Y_OFF + IMG_H);
    brd = !img && (h >= X_OFF - 1) && (h <= X_OFF + IMG_W) &&
          (v >= Y_OFF - 1) && (v <= Y_OFF + IMG_H);
    if (v >= 480) begin
      m_pixels = 0;
      m_addr   = 16'h0000;
    end else if (img) begin
      m_addr   = 16'(m_pixels);
      m_pixels = (m_pixels + 1) % 65536;
    end
    rgb = 12'h000;
    if (act && img) rgb = {3{m_addr[7:4]}};
    else if (act && brd) rgb = 12'h00F;
    exp_q.push_back({rgb, hs, vs});
    if (exp_q.size() > 3) dropped = exp_q.pop_front();
    exp_out = exp_q[0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n       = 1'b1;
    buf_sel_req   = 1'b0;
    H_count_value = 11'd0;
    V_count_value = 11'd0;
    Hsync_in      = 1'b1;
    Vsync_in      = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk_25MHz);
    #1;
    n_chk++; if (fs_bus.rd_addr !== 16'h0000) $display("FAIL reset_rd_addr got=%h exp=0000", fs_bus.rd_addr); else n_pass++;
    n_chk++; if (fs_bus.rd_buf !== 1'b0) $display("FAIL reset_rd_buf got=%b exp=0", fs_bus.rd_buf); else n_pass++;
    n_chk++; if (buf_sel_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", buf_sel_ack); else n_pass++;
    n_chk++; if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", {red, green, blue}); else n_pass++;
    n_chk++; if ({Hsync, Vsync} !== 2'b11) $display("FAIL reset_sync got=%b exp=11", {Hsync, Vsync}); else n_pass++;
    @(negedge clk_25MHz);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_frame_clear();
    drive(0, 480, 1'b1, 1'b1);
    n_chk++; if (fs_bus.rd_addr !== 16'h0000) $display("FAIL clear_rd_addr got=%h exp=0000", fs_bus.rd_addr); else n_pass++;
  endtask

  // Full image window including its one-pixel frame, line by line.
  task automatic test_image_sweep();
    for (int v = Y_OFF - 1; v <= Y_OFF + IMG_H; v++) begin
      for (int h = X_OFF - 1; h <= X_OFF + IMG_W; h++) begin
        drive(h, v, 1'b1, 1'b1);
        n_chk++; if (obs_out !== exp_out) $display("FAIL sweep_out h=%0d v=%0d got=%h exp=%h", h, v, obs_out, exp_out); else n_pass++;
        if (h >= X_OFF && h < X_OFF + IMG_W && v >= Y_OFF && v < Y_OFF + IMG_H) begin
          n_chk++;
          if (fs_bus.rd_addr !== 16'((v - Y_OFF) * IMG_W + (h - X_OFF)))
            $display("FAIL sweep_addr h=%0d v=%0d got=%h exp=%h", h, v, fs_bus.rd_addr, 16'((v - Y_OFF) * IMG_W + (h - X_OFF)));
          else n_pass++;
        end
        if (v == 112 && h == 192) begin
          n_chk++; if (fs_bus.rd_addr !== 16'd0) $display("FAIL first_pixel_addr got=%h exp=0000", fs_bus.rd_addr); else n_pass++;
        end
        if (v == 112 && h == 193) begin
          n_chk++; if (fs_bus.rd_addr !== 16'd1) $display("FAIL second_pixel_addr got=%h exp=0001", fs_bus.rd_addr); else n_pass++;
        end
        if (v == 112 && h == 194) begin  // output now belongs to (192,112)
          n_chk++; if ({red, green, blue} !== 12'h000) $display("FAIL first_pixel_rgb got=%h exp=000", {red, green, blue}); else n_pass++;
        end
        if (v == 112 && h == 195) begin  // output for (193,112)
          n_chk++; if ({red, green, blue} !== 12'h000) $display("FAIL second_pixel_rgb got=%h exp=000", {red, green, blue}); else n_pass++;
        end
        if (v == 112 && h == 210) begin  // output for (208,112), address 16
          n_chk++; if ({red, green, blue} !== 12'h111) $display("FAIL pixel16_rgb got=%h exp=111", {red, green, blue}); else n_pass++;
        end
        if (v == 367 && h == 447) begin
          n_chk++; if (fs_bus.rd_addr !== 16'hFFFF) $display("FAIL last_pixel_addr got=%h exp=ffff", fs_bus.rd_addr); else n_pass++;
        end
        if (v == 368 && h == 448) begin  // below the image: address holds
          n_chk++; if (fs_bus.rd_addr !== 16'hFFFF) $display("FAIL hold_addr got=%h exp=ffff", fs_bus.rd_addr); else n_pass++;
        end
      end
    end
    drive(0, 480, 1'b1, 1'b1);
    n_chk++; if (fs_bus.rd_addr !== 16'h0000) $display("FAIL vblank_clear got=%h exp=0000", fs_bus.rd_addr); else n_pass++;
  endtask

  task automatic test_border_colours();
    int          tab_h[6];
    int          tab_v[6];
    logic [11:0] tab_rgb[4];
    tab_h   = '{191, 448, 100, 700, 0, 0};
    tab_v   = '{112, 200, 50, 10, 0, 0};
    tab_rgb = '{12'h00F, 12'h00F, 12'h000, 12'h000};
    for (int i = 0; i < 6; i++) begin
      drive(tab_h[i], tab_v[i], 1'b1, 1'b1);
      if (i >= 2) begin
        n_chk++;
        if ({red, green, blue} !== tab_rgb[i-2])
          $display("FAIL border_rgb h=%0d v=%0d got=%h exp=%h", tab_h[i-2], tab_v[i-2], {red, green, blue}, tab_rgb[i-2]);
        else n_pass++;
        n_chk++; if (obs_out !== exp_out) $display("FAIL border_out got=%h exp=%h", obs_out, exp_out); else n_pass++;
      end
    end
  endtask

  task automatic test_sync_delay();
    int lows;
    int first_low;
    lows = 0;
    first_low = -1;
    for (int h = 640; h < 802; h++) begin
      drive(h % 800, 10, !(h >= 656 && h <= 751), 1'b1);
      n_chk++; if (obs_out !== exp_out) $display("FAIL hsync_out h=%0d got=%h exp=%h", h, obs_out, exp_out); else n_pass++;
      if (Hsync === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = h;
      end
    end
    n_chk++; if (lows != 96) $display("FAIL hsync_width got=%0d exp=96", lows); else n_pass++;
    n_chk++; if (first_low != 658) $display("FAIL hsync_delay got=%0d exp=658", first_low); else n_pass++;
    lows = 0;
    for (int v = 488; v < 498; v++) begin
      drive(0, v, 1'b1, !(v >= 490 && v <= 491));
      n_chk++; if (obs_out !== exp_out) $display("FAIL vsync_out v=%0d got=%h exp=%h", v, obs_out, exp_out); else n_pass++;
      if (Vsync === 1'b0) lows++;
    end
    n_chk++; if (lows != 2) $display("FAIL vsync_width got=%0d exp=2", lows); else n_pass++;
  endtask

  task automatic test_random();
    int h;
    int v;
    for (int i = 0; i < 3000; i++) begin
      h = int'($urandom_range(799, 0));
      v = int'($urandom_range(523, 0));
      drive(h, v, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n_chk++; if (obs_out !== exp_out) $display("FAIL random_out i=%0d got=%h exp=%h", i, obs_out, exp_out); else n_pass++;
      n_chk++; if (fs_bus.rd_addr !== m_addr) $display("FAIL random_addr i=%0d got=%h exp=%h", i, fs_bus.rd_addr, m_addr); else n_pass++;
    end
  endtask

  task automatic test_buf_swap();
    buf_sel_req = 1'b0;
    drive(0, 0, 1'b1, 1'b1);
    drive(0, 0, 1'b1, 1'b1);
    buf_sel_req = 1'b1;
    drive(0, 100, 1'b1, 1'b1);
    drive(799, 479, 1'b1, 1'b1);
    n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b00) $display("FAIL swap_before got=%b exp=00", {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    drive(0, 480, 1'b1, 1'b1);
    n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b11) $display("FAIL swap_toggle got=%b exp=11", {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      drive(i, 480, 1'b1, 1'b1);
      n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b11) $display("FAIL swap_hold i=%0d got=%b exp=11", i, {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    end
    buf_sel_req = 1'b0;
    drive(6, 480, 1'b1, 1'b1);
    n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b10) $display("FAIL swap_release got=%b exp=10", {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    // Request withdrawn before the boundary.
    drive(0, 0, 1'b1, 1'b1);
    buf_sel_req = 1'b1;
    drive(0, 100, 1'b1, 1'b1);
    buf_sel_req = 1'b0;
    drive(1, 100, 1'b1, 1'b1);
    drive(0, 480, 1'b1, 1'b1);
    n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b10) $display("FAIL swap_cancel got=%b exp=10", {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    // Second swap returns to buffer 0.
    buf_sel_req = 1'b1;
    drive(0, 300, 1'b1, 1'b1);
    drive(0, 480, 1'b1, 1'b1);
    n_chk++; if ({fs_bus.rd_buf, buf_sel_ack} !== 2'b01) $display("FAIL swap_second got=%b exp=01", {fs_bus.rd_buf, buf_sel_ack}); else n_pass++;
    buf_sel_req = 1'b0;
    drive(1, 480, 1'b1, 1'b1);
    n_chk++; if (buf_sel_ack !== 1'b0) $display("FAIL swap_second_release got=%b exp=0", buf_sel_ack); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    drive(0, 480, 1'b1, 1'b1);
    for (int h = 296; h < 300; h++) drive(h, 200, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(191, 200, 1'b0, 1'b0);
    n_chk++; if (obs_out !== exp_out) $display("FAIL pre_reset_out got=%h exp=%h", obs_out, exp_out); else n_pass++;
    H_count_value = 11'd300;
    V_count_value = 11'd200;
    Hsync_in      = 1'b1;
    Vsync_in      = 1'b1;
    #5 reset_n = 1'b0;
    #1;
    n_chk++; if (obs_out !== BLANK) $display("FAIL reset_async_out got=%h exp=%h", obs_out, BLANK); else n_pass++;
    n_chk++; if (fs_bus.rd_addr !== 16'h0000) $display("FAIL reset_async_addr got=%h exp=0000", fs_bus.rd_addr); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_25MHz);
      #1;
      n_chk++; if (obs_out !== BLANK) $display("FAIL reset_hold_out c=%0d got=%h exp=%h", i, obs_out, BLANK); else n_pass++;
      n_chk++; if (fs_bus.rd_addr !== 16'h0000) $display("FAIL reset_hold_addr c=%0d got=%h exp=0000", i, fs_bus.rd_addr); else n_pass++;
    end
    @(negedge clk_25MHz);
    reset_n = 1'b1;
    model_reset();
    // Rest of the interrupted line: addresses restart from zero.
    for (int h = 300; h < 306; h++) begin
      drive(h, 200, 1'b1, 1'b1);
      n_chk++; if (fs_bus.rd_addr !== m_addr) $display("FAIL post_reset_addr h=%0d got=%h exp=%h", h, fs_bus.rd_addr, m_addr); else n_pass++;
      n_chk++; if (obs_out !== exp_out) $display("FAIL post_reset_out h=%0d got=%h exp=%h", h, obs_out, exp_out); else n_pass++;
    end
    drive(0, 480, 1'b1, 1'b1);
    for (int h = X_OFF - 1; h <= X_OFF + IMG_W + 2; h++) begin
      drive(h, 112, 1'b1, 1'b1);
      n_chk++; if (obs_out !== exp_out) $display("FAIL next_frame_out h=%0d got=%h exp=%h", h, obs_out, exp_out); else n_pass++;
      if (h >= X_OFF && h < X_OFF + IMG_W) begin
        n_chk++;
        if (fs_bus.rd_addr !== 16'(h - X_OFF)) $display("FAIL next_frame_addr h=%0d got=%h exp=%h", h, fs_bus.rd_addr, 16'(h - X_OFF));
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_chk  = 0;
    n_pass = 0;
    model_reset();
    test_reset();
    test_frame_clear();
    test_image_sweep();
    test_border_colours();
    test_sync_delay();
    test_buf_swap();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipeline.md
Name: vga_pixel_pipeline

Overview:
- Display-side stage directly downstream of the horizontal and vertical counters in the 640x480 @ 25 MHz VGA output path.
- Consumes H_count_value, V_count_value, Hsync and Vsync from the counters.
- Fetches the denoised or original image (8-bit grayscale) from a dual frame store, centred on screen with a one-pixel border.
- Delays the sync signals to match the memory read latency and drives 12-bit RGB.

Parameters:
IMG_W, 256, image width in pixels (power of two)
IMG_H, 256, image height in lines
X_OFF, 192, first image column
Y_OFF, 112, first image line
ADDR_W, 16, read address width; IMG_W*IMG_H <= 2^ADDR_W
RD_LAT, 2, frame-store read latency in cycles (1..4)
BORDER_RGB, 12'h00F, border colour {r,g,b}

Ports:
clk_25MHz  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
H_count_value  in  11  horizontal count, 0..799
V_count_value  in  11  vertical count, 0..523
Hsync_in  in  1  horizontal sync from counter, active low
Vsync_in  in  1  vertical sync from counter, active low
buf_sel_req  in  1  request to swap displayed buffer (level)
buf_sel_ack  out  1  swap performed
rd_addr  out  ADDR_W  frame-store read address
rd_buf  out  1  frame-store select (0 = original, 1 = denoised)
rd_data  in  8  grayscale pixel, valid RD_LAT cycles after rd_addr
Hsync  out  1  delayed horizontal sync
Vsync  out  1  delayed vertical sync
red, green, blue  out  4 each  pixel colour

Behaviour:
- One clock and one asynchronous active-low reset: clk_25MHz and reset_n. Every register clears on reset_n low, with no clock needed.
- Reset values:
  - rd_addr=0, rd_buf=0, buf_sel_ack=0, red/green/blue=0.
  - Hsync=1 and Vsync=1 (inactive). Every sync-delay stage and every pipe stage clears to "blank, sync inactive".
- Stage 0 (registered, 1 cycle) decodes the inputs:
  - active = H<640 and V<480.
  - in_img = X_OFF<=H<X_OFF+IMG_W and Y_OFF<=V<Y_OFF+IMG_H.
  - border = not in_img, H in [X_OFF-1, X_OFF+IMG_W], V in [Y_OFF-1, Y_OFF+IMG_H].
- Address counter:
  - rd_addr is presented in stage 0 for every in_img pixel. The value presented equals the count of in_img pixels already presented in the frame.
  - Increments after each in_img pixel.
  - Cleared while V>=480.
  - Must read 0 at (X_OFF, Y_OFF) and IMG_W*IMG_H-1 at the last image pixel.
  - Holds its value outside the image. Wraps modulo 2^ADDR_W; wrap is never reached with legal parameters.
- Pipeline: active, in_img and border flags, plus Hsync_in and Vsync_in, pass through a shift of total depth 1+RD_LAT. The RGB output and Hsync/Vsync are therefore exactly 1+RD_LAT cycles after the corresponding count.
- Colour select at the output stage:
  - active and in_img: red=green=blue=rd_data[7:4].
  - active and border: BORDER_RGB.
  - All other cases: 0.
- Buffer-swap FSM, states IDLE, PENDING, ACK:
  - IDLE: buf_sel_req=1 goes to PENDING.
  - PENDING: on frame boundary (stage-0 input V=480 and H=0), toggle rd_buf, set buf_sel_ack=1, go to ACK.
  - PENDING: buf_sel_req=0 before the boundary cancels; go to IDLE with no toggle.
  - PENDING: request and boundary in the same cycle means toggle.
  - ACK: hold buf_sel_ack=1 until buf_sel_req=0. Then clear ack and go to IDLE.
  - rd_buf never changes mid-frame.
- Reset mid-frame:
  - Outputs blank immediately.
  - rd_addr restarts at 0. The image may misalign until the next V>=480 clear.
  - The next frame must be fully correct.

Test Plan:
- Drive counts with H at 0..799 and V at 0..523, RD_LAT=2, rd_data modelled as rd_addr[7:0] with 2-cycle latency.
  - Count (192,112) -> rd_addr=0 one cycle later.
  - RGB = 0x000 three cycles after the count.
  - (193,112) -> RGB nibble 0 at address 1. (208,112) -> RGB 0x111.
- Last image pixel (447,367) -> rd_addr=65535. Count (0,480) -> rd_addr=0 next cycle.
- (191,112) and (448,200) -> RGB 0x00F at latency 3. (100,50) -> 0x000. (700,10) -> 0x000.
- Hsync_in low for H=656..751 -> Hsync low for exactly the same 96 cycles, delayed 3. Same check for Vsync.
- Handshake cases:
  - Raise buf_sel_req at V=100 -> rd_buf toggles 0->1 and ack rises one cycle after count (0,480).
  - Hold req 5 more cycles -> ack stays 1. Drop req -> ack=0 the next cycle.
  - Pulse req low before V=480 -> no toggle.
- Assert reset_n=0 at (300,200) for 3 cycles -> RGB=0, Hsync=Vsync=1, rd_addr=0 during reset. Following frame -> address 0 at (192,112).
